button_sync_debounce: RTL and testbench

BUTTON_SYNC_DEBOUNCE -- requirements
Module: button_sync_debounce

---
 rtl/button_sync_debounce.sv | 199 +++++++++++++++++++
 tb/tb_button_sync_debounce.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_sync_debounce
//  Description : Reset synchronizer plus a bank of independent push-button
//                channels. Each channel synchronizes an inverting, asynchronous
//                button input, debounces it with a four-state FSM and emits a
//                debounced level together with one-cycle press, release and
//                (optionally) long-press event flags.
//  Optional    : define BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN to build the
//                per-channel hold counter and long-press event. Without it,
//                button_long_pressed is tied to 0.
//  Ports       :
//    clock               in   source clock
//    reset_n             in   asynchronous active-low reset
//    button_n            in   [NUM_BUTTONS] raw buttons, 0 = pressed
//    reset_s2_n          out  synchronized reset (async assert, 2-edge release)
//    button_state        out  [NUM_BUTTONS] debounced level, 1 = pressed
//    button_pressed      out  [NUM_BUTTONS] one-cycle press events
//    button_released     out  [NUM_BUTTONS] one-cycle release events
//    button_long_pressed out  [NUM_BUTTONS] one-cycle long-press events
//  Revision    : 1.0  initial release
// ============================================================================
module button_sync_debounce #(
    parameter int NUM_BUTTONS       = 1,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic                   reset_s2_n,
    output logic [NUM_BUTTONS-1:0] button_state,
    output logic [NUM_BUTTONS-1:0] button_pressed,
    output logic [NUM_BUTTONS-1:0] button_released,
    output logic [NUM_BUTTONS-1:0] button_long_pressed
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // The debounce counter only ever needs to hold DEBOUNCE_CYCLES-1.
    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN
    localparam int c_hold_w = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_PRESS_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_PRESS_CYCLES - 1);
`else
    logic w_unused_long;
    assign w_unused_long = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES);
`endif

    // ------------------------------------------------------------------------
    // Reset synchronizer: asserts with reset_n, releases on the second edge.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign reset_s2_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // Per-channel synchronizer, debounce FSM and event generation.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [c_cnt_w-1:0]     r_cnt;
        logic [c_cnt_w-1:0]     w_cnt_nxt;
        logic                   r_pressed;
        logic                   r_released;
        logic                   w_press_evt;
        logic                   w_release_evt;

        // Reset value 1 matches a released (inverting) button, so a button
        // held through reset is seen as a fresh press afterwards.
        always_ff @(posedge clock or negedge reset_s2_n) begin
            if (!reset_s2_n) begin
                r_sync <= '1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], button_n[i]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (!w_s) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_max) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_s) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_max) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Events are registered so they coincide with the first cycle the
        // debounced level shows its new value.
        assign w_press_evt   = (r_state == ST_PRESS_WAIT)   && (w_state_nxt == ST_PRESSED);
        assign w_release_evt = (r_state == ST_RELEASE_WAIT) && (w_state_nxt == ST_IDLE);

        always_ff @(posedge clock or negedge reset_s2_n) begin
            if (!reset_s2_n) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_cnt      <= w_cnt_nxt;
                r_pressed  <= w_press_evt;
                r_released <= w_release_evt;
            end
        end

        assign button_state[i]    = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
        assign button_pressed[i]  = r_pressed;
        assign button_released[i] = r_released;

`ifdef BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN
        logic [c_hold_w-1:0] r_hold;
        logic                r_long;
        logic                w_held;

        assign w_held = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);

        // The hold count saturates at the threshold, so the pulse can fire
        // only once per press; a press ending on the same edge gets no pulse.
        always_ff @(posedge clock or negedge reset_s2_n) begin
            if (!reset_s2_n) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= w_held && (w_state_nxt != ST_IDLE) && (r_hold == c_hold_pre);
                if (w_state_nxt == ST_IDLE) begin
                    r_hold <= '0;
                end else if (w_held && (r_hold != c_hold_max)) begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end

        assign button_long_pressed[i] = r_long;
`else
        assign button_long_pressed[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_button_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_sync_debounce
//  Description : Self-checking bench for button_sync_debounce with
//                NUM_BUTTONS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//                LONG_PRESS_CYCLES=20. Expected outputs come from a run-length
//                reference model: a level is accepted once the synchronized
//                input has differed from the accepted level for
//                DEBOUNCE_CYCLES+1 consecutive samples.
//  Optional    : honours BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN for expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_sync_debounce;

    localparam int NB   = 2;
    localparam int SS   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NB-1:0] button_n;
    logic          reset_s2_n;
    logic [NB-1:0] button_state;
    logic [NB-1:0] button_pressed;
    logic [NB-1:0] button_released;
    logic [NB-1:0] button_long_pressed;
    logic [4*NB:0] dut_vec;

    button_sync_debounce #(
        .NUM_BUTTONS      (NB),
        .SYNC_STAGES      (SS),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .button_n           (button_n),
        .reset_s2_n         (reset_s2_n),
        .button_state       (button_state),
        .button_pressed     (button_pressed),
        .button_released    (button_released),
        .button_long_pressed(button_long_pressed)
    );

    always #5 clock = ~clock;

    assign dut_vec = {reset_s2_n, button_state, button_pressed, button_released, button_long_pressed};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [NB-1:0] m_dline[$];
    logic [NB-1:0] m_acc;
    logic [NB-1:0] m_ev_p;
    logic [NB-1:0] m_ev_r;
    logic [NB-1:0] m_ev_l;
    int            m_run[NB];
    int            m_held[NB];
    int            m_rs;

    task automatic m_reset();
        m_dline.delete();
        for (int i = 0; i < SS; i++) m_dline.push_back({NB{1'b1}});
        m_acc  = '0;
        m_ev_p = '0;
        m_ev_r = '0;
        m_ev_l = '0;
        m_rs   = 0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
    endtask

    // One active clock edge; raw is the button value sampled at that edge.
    task automatic m_edge(input logic [NB-1:0] raw);
        logic [NB-1:0] s;
        bit            active;
        active = (m_rs >= 2);
        if (reset_n && m_rs < 2) m_rs++;
        m_ev_p = '0;
        m_ev_r = '0;
        m_ev_l = '0;
        if (!active) return;
        s = m_dline.pop_front();
        m_dline.push_back(raw);
        for (int c = 0; c < NB; c++) begin
            logic was;
            was = m_acc[c];
            if ((!s[c]) != m_acc[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == DEB + 1) begin
                m_acc[c] = ~m_acc[c];
                m_run[c] = 0;
                if (m_acc[c]) m_ev_p[c] = 1'b1;
                else m_ev_r[c] = 1'b1;
            end
            if (was && m_acc[c]) begin
                m_held[c]++;
                if (m_held[c] == LONG) m_ev_l[c] = 1'b1;
            end else begin
                m_held[c] = 0;
            end
        end
    endtask

    function automatic logic [4*NB:0] m_exp();
        logic [NB-1:0] l;
`ifdef BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN
        l = m_ev_l;
`else
        l = '0;
`endif
        return {(m_rs >= 2), m_acc, m_ev_p, m_ev_r, l};
    endfunction

    task automatic step(input logic [NB-1:0] bn);
        button_n = bn;
        @(posedge clock);
        m_edge(bn);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        button_n = '1;
        #1;
        reset_n = 1'b0;
        m_reset();
        step('1);
        step('1);
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_outputs got=%b exp=%b", dut_vec, {(4*NB+1){1'b0}});
        else n_pass++;
        reset_n = 1'b1;
        step('1);
        n_checks++;
        if (reset_s2_n !== 1'b0) $display("FAIL reset_rel_edge1 got=%b exp=0", reset_s2_n);
        else n_pass++;
        step('1);
        n_checks++;
        if (reset_s2_n !== 1'b1) $display("FAIL reset_rel_edge2 got=%b exp=1", reset_s2_n);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step('1);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL reset_idle cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
        end
    endtask

    task automatic test_single_press();
        int t_press;
        int n_press;
        bit ch1_noise;
        t_press   = -1;
        n_press   = 0;
        ch1_noise = 0;
        for (int k = 0; k < 12; k++) begin
            step(2'b10);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL single_press cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
            if (button_pressed[0]) begin
                n_press++;
                if (t_press < 0) t_press = k;
            end
            if (button_pressed[1] || button_state[1]) ch1_noise = 1;
        end
        n_checks++;
        if (t_press != SS + DEB) $display("FAIL press_latency got=%0d exp=%0d", t_press, SS + DEB);
        else n_pass++;
        n_checks++;
        if (n_press != 1) $display("FAIL press_count got=%0d exp=1", n_press);
        else n_pass++;
        n_checks++;
        if (button_state[0] !== 1'b1 || ch1_noise) $display("FAIL press_state got=%b ch1_noise=%0d exp=1/0", button_state[0], ch1_noise);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            step(2'b11);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL single_release cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        bit seen;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step((k < 3) ? 2'b10 : 2'b11);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL bounce cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
            if (button_pressed[0] || button_state[0]) seen = 1;
        end
        n_checks++;
        if (seen) $display("FAIL bounce_event got=1 exp=0");
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int n_both_p, n_both_r, n_split;
        n_both_p = 0;
        n_both_r = 0;
        n_split  = 0;
        for (int k = 0; k < 24; k++) begin
            step((k < 12) ? 2'b00 : 2'b11);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL simultaneous cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
            if (button_pressed == 2'b11) n_both_p++;
            if (button_released == 2'b11) n_both_r++;
            if (button_pressed == 2'b01 || button_pressed == 2'b10 ||
                button_released == 2'b01 || button_released == 2'b10) n_split++;
        end
        n_checks++;
        if (n_both_p != 1 || n_both_r != 1 || n_split != 0)
            $display("FAIL simultaneous_events got=p%0d/r%0d/split%0d exp=p1/r1/split0", n_both_p, n_both_r, n_split);
        else n_pass++;
    endtask

    task automatic test_long_press();
        int t_rise, t_long, n_long, exp_n;
        t_rise = -1;
        t_long = -1;
        n_long = 0;
        for (int k = 0; k < 55; k++) begin
            step((k < 45) ? 2'b01 : 2'b11);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL long_press cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
            if (button_state[1] && t_rise < 0) t_rise = k;
            if (button_long_pressed[1]) begin
                n_long++;
                if (t_long < 0) t_long = k;
            end
        end
`ifdef BUTTON_SYNC_DEBOUNCE_LONG_PRESS_EN
        exp_n = 1;
        n_checks++;
        if (t_long - t_rise != LONG) $display("FAIL long_offset got=%0d exp=%0d", t_long - t_rise, LONG);
        else n_pass++;
`else
        exp_n = 0;
`endif
        n_checks++;
        if (n_long != exp_n) $display("FAIL long_count got=%0d exp=%0d", n_long, exp_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_press;
        n_press = 0;
        for (int k = 0; k < 5; k++) begin
            step(2'b10);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
        end
        reset_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_mid_clear got=%b exp=%b", dut_vec, {(4*NB+1){1'b0}});
        else n_pass++;
        step(2'b10);
        step(2'b10);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(2'b10);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL reset_mid_post cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
            if (button_pressed[0]) n_press++;
        end
        n_checks++;
        if (n_press != 1) $display("FAIL reset_mid_press_count got=%0d exp=1", n_press);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            step(2'b11);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL reset_mid_release cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int            dur[NB];
        logic [NB-1:0] lvl;
        lvl = '1;
        for (int c = 0; c < NB; c++) dur[c] = 0;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (dur[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 35));
                end
                dur[c]--;
            end
            if (k == 400) begin
                reset_n = 1'b0;
                m_reset();
                #1;
                n_checks++;
                if (dut_vec !== m_exp()) $display("FAIL random_reset got=%b exp=%b", dut_vec, m_exp());
                else n_pass++;
            end
            if (k == 403) reset_n = 1'b1;
            step(lvl);
            n_checks++;
            if (dut_vec !== m_exp()) $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_vec, m_exp());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
